g25_hex_display_ctrl: RTL and testbench

Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment displays from a packed nibble register, with hardware hex decode, per-digit blank and blink masks, lamp test and an atomic add port. It replaces the plain per-pair 16-bit output ports hanging off the Nios bus in g25_SHA256_system. One instance drives all six HEX displays.

---
 rtl/g25_hex_display_pkg.sv | 28 ++
 rtl/g25_hex7seg_decoder.sv | 32 +++
 rtl/g25_hex_display_ctrl.sv | 126 ++++++++++++
 tb/tb_g25_hex_display_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/g25_hex_display_pkg.sv
// Shared constants for the g25 hex display controller: register addresses,
// CTRL bit positions, special segment patterns and a byte-lane mask helper.
package g25_hex_display_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLANK  = 3'd1;
  localparam logic [2:0] ADDR_BLINK  = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_ADD    = 3'd5;

  localparam int CTRL_BLINK_EN  = 0;
  localparam int CTRL_LAMP_TEST = 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ALL   = 7'h00;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Expands the four Avalon byte enables into a 32-bit write mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/g25_hex7seg_decoder.sv
// Combinational nibble to active-low seven-segment decode (bit 0 = seg a).
module g25_hex7seg_decoder
  import g25_hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/g25_hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment displays with hex decode,
// blank/blink masks, lamp test and an atomic add port on the DATA register.
module g25_hex_display_ctrl
  import g25_hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  input  logic [3:0]              byteenable,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int D  = 4 * NUM_DIGITS;
  localparam int M  = NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [D-1:0]            data_q,  data_d;
  logic [M-1:0]            blank_q, blank_d;
  logic [M-1:0]            blink_q, blink_d;
  logic [1:0]              ctrl_q,  ctrl_d;
  logic [CW-1:0]           cnt_q,   cnt_d;
  logic                    phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] hex_q,   hex_d;

  logic        wr_en;
  logic [31:0] wmask;
  logic        unused_bits;
  logic [6:0]  dec [NUM_DIGITS];

  assign wr_en       = chipselect && !write_n;
  assign wmask       = be_mask(byteenable);
  assign unused_bits = ^{wmask, writedata};

  always_comb begin
    data_d  = data_q;
    blank_d = blank_q;
    blink_d = blink_q;
    ctrl_d  = ctrl_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:  data_d  = (data_q  & ~wmask[D-1:0]) | (writedata[D-1:0] & wmask[D-1:0]);
        ADDR_BLANK: blank_d = (blank_q & ~wmask[M-1:0]) | (writedata[M-1:0] & wmask[M-1:0]);
        ADDR_BLINK: blink_d = (blink_q & ~wmask[M-1:0]) | (writedata[M-1:0] & wmask[M-1:0]);
        ADDR_CTRL:  ctrl_d  = (ctrl_q  & ~wmask[1:0])   | (writedata[1:0]   & wmask[1:0]);
        ADDR_ADD:   data_d  = data_q + writedata[D-1:0];
        default:    ;
      endcase
    end
  end

  // Counting requires BLINK_EN both now and after this edge, so a clearing
  // write beats a terminal count and a setting write starts from zero.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (ctrl_q[CTRL_BLINK_EN] && ctrl_d[CTRL_BLINK_EN]) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    g25_hex7seg_decoder u_dec (
      .nibble_i (data_q[4*g +: 4]),
      .seg_o    (dec[g])
    );
  end

  always_comb begin
    hex_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ctrl_q[CTRL_LAMP_TEST])          hex_d[7*i +: 7] = SEG_ALL;
      else if (blank_q[i])                 hex_d[7*i +: 7] = SEG_BLANK;
      else if (blink_q[i] && phase_q)      hex_d[7*i +: 7] = SEG_BLANK;
      else                                 hex_d[7*i +: 7] = dec[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      blank_q <= '0;
      blink_q <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      data_q  <= data_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_BLANK:  readdata = 32'(blank_q);
      ADDR_BLINK:  readdata = 32'(blink_q);
      ADDR_CTRL:   readdata = {30'd0, ctrl_q};
      ADDR_STATUS: readdata = {31'd0, phase_q};
      default:     readdata = '0;
    endcase
  end

  assign hex_out = hex_q;

endmodule

// File: tb/tb_g25_hex_display_ctrl.sv
// Scoreboard bench for g25_hex_display_ctrl with NUM_DIGITS=6, BLINK_DIV=4.
module tb_g25_hex_display_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic [41:0] hex_out;

  typedef struct {
    string       name;
    logic [41:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;

  g25_hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference segment table, active-low g..a.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [41:0] hex_of(input logic [23:0] d);
    logic [41:0] r;
    for (int i = 0; i < ND; i++) r[7*i +: 7] = seg_of(d[4*i +: 4]);
    return r;
  endfunction

  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address    = a;
    writedata  = d;
    byteenable = be;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    byteenable = 4'h0;
  endtask

  task automatic expect_read(input string name, input logic [2:0] a, input logic [31:0] v);
    sb.push_back('{name, 42'(v)});
    @(negedge clk);
    address = a;
    #1;
    e = sb.pop_front();
    checks++;
    if (42'(readdata) !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: readdata=%h expected %h", e.name, readdata, e.exp[31:0]);
    end
  endtask

  task automatic expect_hex_next_edge(input string name, input logic [41:0] v);
    sb.push_back('{name, v});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (hex_out !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: hex_out=%h expected %h", e.name, hex_out, e.exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = '0; byteenable = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      sb.push_back('{$sformatf("reset_rd%0d", a), 42'd0});
      address = 3'(a);
      #1;
      e = sb.pop_front();
      checks++;
      if (42'(readdata) !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: readdata=%h expected %h", e.name, readdata, e.exp[31:0]);
      end
    end
    sb.push_back('{"reset_hex", {ND{7'h40}}});
    e = sb.pop_front();
    checks++;
    if (hex_out !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: hex_out=%h expected %h", e.name, hex_out, e.exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    expect_hex_next_edge("post_reset_hex", {ND{7'h40}});
    expect_read("post_reset_data", 3'd0, 32'h0);
  endtask

  task automatic test_decode();
    logic [23:0] pats [3];
    pats = '{24'h543210, 24'hBA9876, 24'hFEDCBA};
    for (int p = 0; p < 3; p++) begin
      applyStimulus(3'd0, 32'(pats[p]), 4'hF);
      expect_hex_next_edge($sformatf("decode_hex%0d", p), hex_of(pats[p]));
    end
    sb.push_back('{"decode_spec_vec", {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}});
    e = sb.pop_front();
    checks++;
    if (hex_out !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: hex_out=%h expected %h", e.name, hex_out, e.exp);
    end
    expect_read("decode_rd", 3'd0, 32'h00FEDCBA);
  endtask

  task automatic test_byteenable();
    applyStimulus(3'd0, 32'h00123456, 4'hF);
    applyStimulus(3'd0, 32'hFFFFFFFF, 4'b0010);
    expect_read("be_lane1", 3'd0, 32'h0012FF56);
    applyStimulus(3'd0, 32'hFFFFFFFF, 4'b1000);
    expect_read("be_lane3_discard", 3'd0, 32'h0012FF56);
    applyStimulus(3'd0, 32'h00AB0000, 4'b0100);
    expect_read("be_lane2", 3'd0, 32'h00ABFF56);
    applyStimulus(3'd3, 32'hFFFFFFFF, 4'b1110);
    expect_read("ctrl_be_off", 3'd3, 32'h0);
  endtask

  task automatic test_add();
    applyStimulus(3'd0, 32'h00FFFFFE, 4'hF);
    applyStimulus(3'd5, 32'h00000003, 4'h0);
    expect_read("add_wrap", 3'd0, 32'h00000001);
    expect_read("add_reads0", 3'd5, 32'h0);
    expect_hex_next_edge("add_hex", hex_of(24'h000001));
    applyStimulus(3'd0, 32'h00FFFFFF, 4'hF);
    applyStimulus(3'd5, 32'h00000001, 4'hF);
    expect_read("add_ones_plus1", 3'd0, 32'h0);
    applyStimulus(3'd0, 32'h0000000F, 4'hF);
    applyStimulus(3'd5, 32'h00000001, 4'h0);
    expect_read("add_nibble_carry", 3'd0, 32'h00000010);
    applyStimulus(3'd5, 32'hFF000001, 4'h0);
    expect_read("add_upper_discard", 3'd0, 32'h00000011);
  endtask

  task automatic test_registers();
    applyStimulus(3'd1, 32'hFFFFFFFF, 4'hF);
    expect_read("blank_width", 3'd1, 32'h3F);
    applyStimulus(3'd1, 32'h0, 4'hF);
    applyStimulus(3'd2, 32'h0000002A, 4'hF);
    expect_read("blink_rd", 3'd2, 32'h2A);
    applyStimulus(3'd2, 32'h0, 4'hF);
    applyStimulus(3'd4, 32'hFFFFFFFF, 4'hF);
    expect_read("status_ro", 3'd4, 32'h0);
    applyStimulus(3'd6, 32'hFFFFFFFF, 4'hF);
    applyStimulus(3'd7, 32'hFFFFFFFF, 4'hF);
    expect_read("addr6_zero", 3'd6, 32'h0);
    expect_read("addr7_zero", 3'd7, 32'h0);
    expect_read("data_untouched", 3'd0, 32'h00000011);
  endtask

  task automatic test_blink();
    logic        ph;
    logic [41:0] hx;
    applyStimulus(3'd0, 32'h00000007, 4'hF);
    applyStimulus(3'd2, 32'h00000001, 4'hF);
    applyStimulus(3'd3, 32'h00000001, 4'hF);
    address = 3'd4;
    for (int j = 1; j < 12; j++) begin
      ph = ((j / BD) % 2) == 1;
      hx = hex_of(24'h000007);
      if (((j - 1) / BD) % 2 == 1) hx[6:0] = 7'h7F;
      sb.push_back('{$sformatf("blink_status_c%0d", j), 42'(ph)});
      sb.push_back('{$sformatf("blink_hex_c%0d", j), hx});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (42'(readdata) !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: status=%h expected %h", e.name, readdata, e.exp[31:0]);
      end
      e = sb.pop_front();
      checks++;
      if (hex_out !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: hex_out=%h expected %h", e.name, hex_out, e.exp);
      end
    end
    applyStimulus(3'd3, 32'h00000000, 4'hF);
    address = 3'd4;
    for (int j = 0; j < 6; j++) begin
      sb.push_back('{$sformatf("blink_off_status%0d", j), 42'd0});
      sb.push_back('{$sformatf("blink_off_hex%0d", j), hex_of(24'h000007)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (42'(readdata) !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: status=%h expected %h", e.name, readdata, e.exp[31:0]);
      end
      e = sb.pop_front();
      checks++;
      if (hex_out !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: hex_out=%h expected %h", e.name, hex_out, e.exp);
      end
    end
  endtask

  task automatic test_priority();
    applyStimulus(3'd1, 32'h0000003F, 4'hF);
    applyStimulus(3'd3, 32'h00000002, 4'hF);
    expect_hex_next_edge("lamp_test_all_on", {ND{7'h00}});
    applyStimulus(3'd3, 32'h00000000, 4'hF);
    expect_hex_next_edge("blank_all_dark", {ND{7'h7F}});
    applyStimulus(3'd1, 32'h00000000, 4'hF);
    expect_hex_next_edge("unblank", hex_of(24'h000007));
  endtask

  task automatic test_async_reset();
    applyStimulus(3'd0, 32'h00ABCDEF, 4'hF);
    applyStimulus(3'd3, 32'h00000001, 4'hF);
    repeat (3) @(posedge clk);
    address = 3'd0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back('{"async_rst_hex", {ND{7'h40}}});
    sb.push_back('{"async_rst_data", 42'd0});
    e = sb.pop_front();
    checks++;
    if (hex_out !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: hex_out=%h expected %h", e.name, hex_out, e.exp);
    end
    e = sb.pop_front();
    checks++;
    if (42'(readdata) !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: readdata=%h expected %h", e.name, readdata, e.exp[31:0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    expect_read("async_rst_ctrl", 3'd3, 32'h0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_byteenable();
    test_add();
    test_registers();
    test_blink();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
